unified_mem_arbiter: RTL and testbench

- Shares one single-port memory between the instruction-fetch requester (IF, read-only) and the data-memory requester (MEM, read/write).
- The shared memory has a variable-latency req/ack handshake.
- Sits between the pipeline stages and the shared memory. Produces per-requester ready pulses and stall levels, which the pipeline uses to freeze PCWrite and the pipeline registers.
- MEM has priority, with a starvation guard for IF and a timeout on the memory acknowledge.

---
 rtl/unified_mem_arbiter_if.sv | 59 +++++
 rtl/unified_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 531 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if
// Bundles every handshake/bus signal of the unified memory arbiter so the
// pipeline side, the shared memory side and the arbiter share one port.
//
// Signal groups:
//   IF requester  : if_req, if_addr (to arbiter) / if_rdata, if_ready, if_stall
//   MEM requester : mem_rd, mem_wr, mem_addr, mem_wdata (to arbiter) /
//                   mem_rdata, mem_ready, mem_stall
//   status        : bus_err (aborted transaction, pulses with ready)
//   shared memory : port_req, port_we, port_addr, port_wdata (from arbiter) /
//                   port_rdata, port_ack (to arbiter)
//
// Modports:
//   master : the arbiter itself
//   slave  : the environment (pipeline stages plus the shared memory)

interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              if_stall;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_stall;

  logic              bus_err;

  logic              port_req;
  logic              port_we;
  logic [ADDR_W-1:0] port_addr;
  logic [DATA_W-1:0] port_wdata;
  logic [DATA_W-1:0] port_rdata;
  logic              port_ack;

  modport master (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
           port_rdata, port_ack,
    output if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
           bus_err, port_req, port_we, port_addr, port_wdata
  );

  modport slave (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
           port_rdata, port_ack,
    input  if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
           bus_err, port_req, port_we, port_addr, port_wdata
  );

endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port, variable-latency memory between the instruction
// fetch requester (read-only) and the data memory requester (read/write).
// MEM normally wins; IF is forced through after STARVE_MAX consecutive MEM
// grants taken while it waited. A grant that sees no acknowledge within
// TIMEOUT cycles is aborted and reported with bus_err.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : unified_mem_arbiter_if.master (requester and memory signals)
//
// Parameters: ADDR_W, DATA_W, STARVE_MAX (1..15), TIMEOUT (2..255)

module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  unified_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM, RESP} stateT;

  stateT       state;
  stateT       nextState;
  logic [3:0]  starveCnt;
  logic [7:0]  tmoCnt;

  logic        memReq;
  logic        starveHit;
  logic        inGrant;
  logic        tmoHit;
  logic        grantMem;
  logic        grantIf;
  logic        ackDone;
  logic        abortDone;

  assign memReq    = bus.mem_rd | bus.mem_wr;
  // IF only overrides MEM priority when it is actually waiting
  assign starveHit = bus.if_req & (starveCnt == 4'(STARVE_MAX));
  assign inGrant   = (state == GNT_IF) || (state == GNT_MEM);
  assign tmoHit    = (tmoCnt == 8'(TIMEOUT - 1));

  assign bus.if_stall  = bus.if_req & ~bus.if_ready;
  assign bus.mem_stall = memReq & ~bus.mem_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; RESP always lasts exactly one cycle
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (grantMem) begin
          nextState = GNT_MEM;
        end else if (grantIf) begin
          nextState = GNT_IF;
        end
      end
      GNT_IF, GNT_MEM: begin
        if (ackDone || abortDone) begin
          nextState = RESP;
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output decode: grant and completion strobes. port_ack is only honoured
  // in a grant state, so stray acknowledges in IDLE/RESP are dropped.
  always_comb begin
    grantMem  = 1'b0;
    grantIf   = 1'b0;
    ackDone   = 1'b0;
    abortDone = 1'b0;
    case (state)
      IDLE: begin
        if (memReq && !starveHit) begin
          grantMem = 1'b1;
        end else if (bus.if_req) begin
          grantIf = 1'b1;
        end
      end
      GNT_IF, GNT_MEM: begin
        if (bus.port_ack) begin
          ackDone = 1'b1;
        end else if (tmoHit) begin
          abortDone = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered datapath. Ready/bus_err are set on the edge into RESP so they
  // are high for exactly the RESP cycle; the default clear ends the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.port_req   <= 1'b0;
      bus.port_we    <= 1'b0;
      bus.port_addr  <= {ADDR_W{1'b0}};
      bus.port_wdata <= {DATA_W{1'b0}};
      bus.if_rdata   <= {DATA_W{1'b0}};
      bus.mem_rdata  <= {DATA_W{1'b0}};
      bus.if_ready   <= 1'b0;
      bus.mem_ready  <= 1'b0;
      bus.bus_err    <= 1'b0;
      starveCnt      <= 4'd0;
      tmoCnt         <= 8'd0;
    end else begin
      bus.if_ready  <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.bus_err   <= 1'b0;

      if (grantMem) begin
        bus.port_req   <= 1'b1;
        bus.port_we    <= bus.mem_wr;
        bus.port_addr  <= bus.mem_addr;
        bus.port_wdata <= bus.mem_wdata;
        if (!bus.if_req) begin
          starveCnt <= 4'd0;
        end else if (starveCnt != 4'(STARVE_MAX)) begin
          starveCnt <= starveCnt + 4'd1;
        end
      end

      if (grantIf) begin
        bus.port_req   <= 1'b1;
        bus.port_we    <= 1'b0;
        bus.port_addr  <= bus.if_addr;
        bus.port_wdata <= {DATA_W{1'b0}};
        starveCnt      <= 4'd0;
      end

      if (inGrant) begin
        tmoCnt <= tmoCnt + 8'd1;
      end

      if (ackDone || abortDone) begin
        bus.port_req <= 1'b0;
        bus.bus_err  <= abortDone;
        if (state == GNT_IF) begin
          bus.if_ready <= 1'b1;
        end else begin
          bus.mem_ready <= 1'b1;
        end
      end

      // Writes and aborted reads leave the read-data registers untouched
      if (ackDone && !bus.port_we) begin
        if (state == GNT_IF) begin
          bus.if_rdata <= bus.port_rdata;
        end else begin
          bus.mem_rdata <= bus.port_rdata;
        end
      end

      if (state == RESP) begin
        tmoCnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter
// Self-checking bench for unified_mem_arbiter: directed scenarios followed
// by a randomized traffic run compared against a transaction-level model
// (pending requests, starvation count, expected ready cycle, memory image).

module tb_unified_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  unified_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks  = 0;
  int errors  = 0;
  int cycleNo = 0;

  logic [31:0] memArr [64];
  logic [31:0] refMem [64];

  bit respEnable  = 1'b1;
  bit respNever   = 1'b0;
  int respMaxWait = 0;
  int respWait    = 0;
  int respCnt     = 0;
  bit lastReq     = 1'b0;
  bit reqRose     = 1'b0;

  // Advance to the next falling edge and play the shared memory: ack after
  // respWait extra cycles of port_req, with junk on port_rdata otherwise.
  task automatic stepCycle();
    @(negedge clk);
    cycleNo++;
    reqRose = bus.port_req && !lastReq;
    lastReq = bus.port_req;
    if (reqRose) begin
      respWait = (respMaxWait == 0) ? 0 : int'($urandom_range(respMaxWait, 0));
      respCnt  = 0;
    end
    if (!bus.port_req) respCnt = 0;
    if (respEnable) begin
      bus.port_ack   = 1'b0;
      bus.port_rdata = $urandom;
      if (bus.port_req && !respNever) begin
        if (respCnt == respWait) begin
          bus.port_ack = 1'b1;
          if (bus.port_we) memArr[bus.port_addr[7:2]] = bus.port_wdata;
          else             bus.port_rdata = memArr[bus.port_addr[7:2]];
        end else begin
          respCnt++;
        end
      end
    end
  endtask

  task automatic clearInputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
  endtask

  task automatic test_reset();
    clearInputs();
    #2 rst_n = 1'b0;
    repeat (2) stepCycle();
    checks++;
    if ({bus.port_req, bus.port_we, bus.if_ready, bus.mem_ready, bus.bus_err} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b want 00000",
               {bus.port_req, bus.port_we, bus.if_ready, bus.mem_ready, bus.bus_err});
    end
    checks++;
    if (bus.port_addr !== 32'h0 || bus.port_wdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_port got addr %h wdata %h want 0", bus.port_addr, bus.port_wdata);
    end
    checks++;
    if (bus.if_rdata !== 32'h0 || bus.mem_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rdata got if %h mem %h want 0", bus.if_rdata, bus.mem_rdata);
    end
    rst_n = 1'b1;
    stepCycle();
  endtask

  task automatic test_if_read();
    respMaxWait = 0;
    memArr[16]  = 32'h8C020004;
    bus.if_addr = 32'h40;
    bus.if_req  = 1'b1;
    #1;
    checks++;
    if (bus.if_stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL if_stall_pre got %b want 1", bus.if_stall);
    end
    stepCycle();
    checks++;
    if ({bus.port_req, bus.port_we, bus.port_addr, bus.if_ready} !== {1'b1, 1'b0, 32'h40, 1'b0}) begin
      errors++;
      $display("[TB] FAIL if_grant got req %b we %b addr %h rdy %b want 1 0 00000040 0",
               bus.port_req, bus.port_we, bus.port_addr, bus.if_ready);
    end
    stepCycle();
    checks++;
    if ({bus.if_ready, bus.mem_ready, bus.bus_err, bus.if_stall} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL if_ready got rdy %b mrdy %b err %b stall %b want 1 0 0 0",
               bus.if_ready, bus.mem_ready, bus.bus_err, bus.if_stall);
    end
    checks++;
    if (bus.if_rdata !== 32'h8C020004) begin
      errors++;
      $display("[TB] FAIL if_rdata got %h want 8c020004", bus.if_rdata);
    end
    bus.if_req = 1'b0;
    stepCycle();
    checks++;
    if ({bus.if_ready, bus.port_req} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL if_pulse_end got rdy %b req %b want 0 0", bus.if_ready, bus.port_req);
    end
  endtask

  task automatic test_priority();
    memArr[32]    = 32'h11223344;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h80;
    bus.mem_wr    = 1'b1;
    bus.mem_addr  = 32'h10;
    bus.mem_wdata = 32'hDEADBEEF;
    stepCycle();
    checks++;
    if ({bus.port_req, bus.port_we, bus.port_addr, bus.port_wdata} !== {2'b11, 32'h10, 32'hDEADBEEF}) begin
      errors++;
      $display("[TB] FAIL prio_mem_grant got req %b we %b addr %h wdata %h want 1 1 00000010 deadbeef",
               bus.port_req, bus.port_we, bus.port_addr, bus.port_wdata);
    end
    checks++;
    if ({bus.if_stall, bus.mem_stall} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL prio_stall_wait got %b want 11", {bus.if_stall, bus.mem_stall});
    end
    stepCycle();
    checks++;
    if ({bus.mem_ready, bus.if_ready, bus.bus_err, bus.mem_stall, bus.if_stall} !== 5'b10001) begin
      errors++;
      $display("[TB] FAIL prio_mem_ready got %b want 10001",
               {bus.mem_ready, bus.if_ready, bus.bus_err, bus.mem_stall, bus.if_stall});
    end
    bus.mem_wr = 1'b0;
    stepCycle();
    checks++;
    if ({bus.port_req, bus.if_stall} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL prio_gap got req %b stall %b want 0 1", bus.port_req, bus.if_stall);
    end
    stepCycle();
    checks++;
    if ({bus.port_req, bus.port_we, bus.port_addr} !== {2'b10, 32'h80}) begin
      errors++;
      $display("[TB] FAIL prio_if_grant got req %b we %b addr %h want 1 0 00000080",
               bus.port_req, bus.port_we, bus.port_addr);
    end
    stepCycle();
    checks++;
    if ({bus.if_ready, bus.if_rdata} !== {1'b1, 32'h11223344}) begin
      errors++;
      $display("[TB] FAIL prio_if_ready got rdy %b data %h want 1 11223344", bus.if_ready, bus.if_rdata);
    end
    checks++;
    if (memArr[4] !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL prio_mem_write got %h want deadbeef", memArr[4]);
    end
    bus.if_req = 1'b0;
    stepCycle();
  endtask

  task automatic test_starvation();
    logic [11:0] expMem = 12'b1111_0111_1011;
    int g = 0;
    bit done = 1'b0;
    respMaxWait  = 2;
    memArr[8]    = 32'hA5A5A5A5;
    bus.if_addr  = 32'h44;
    bus.mem_addr = 32'h20;
    bus.if_req   = 1'b1;
    bus.mem_rd   = 1'b1;
    for (int c = 0; c < 150 && g < 12; c++) begin
      stepCycle();
      if (reqRose) begin
        checks++;
        if ((bus.port_addr == 32'h20) !== expMem[11-g]) begin
          errors++;
          $display("[TB] FAIL starve_grant%0d got mem %b want mem %b",
                   g, (bus.port_addr == 32'h20), expMem[11-g]);
        end
        g++;
      end
    end
    checks++;
    if (g != 12) begin
      errors++;
      $display("[TB] FAIL starve_budget got %0d grants want 12", g);
    end
    for (int c = 0; c < 20 && !done; c++) begin
      stepCycle();
      if (bus.if_ready || bus.mem_ready) done = 1'b1;
    end
    bus.if_req = 1'b0;
    bus.mem_rd = 1'b0;
    repeat (2) stepCycle();
  endtask

  task automatic test_timeout();
    int hi = 0;
    bit done = 1'b0;
    respMaxWait  = 0;
    memArr[12]   = 32'h12345678;
    bus.mem_addr = 32'h30;
    bus.mem_rd   = 1'b1;
    for (int c = 0; c < 10 && !done; c++) begin
      stepCycle();
      if (bus.mem_ready) done = 1'b1;
    end
    bus.mem_rd = 1'b0;
    checks++;
    if ({done, bus.mem_rdata} !== {1'b1, 32'h12345678}) begin
      errors++;
      $display("[TB] FAIL tmo_baseline got done %b data %h want 1 12345678", done, bus.mem_rdata);
    end
    stepCycle();
    respNever    = 1'b1;
    memArr[13]   = 32'h0BADF00D;
    bus.mem_addr = 32'h34;
    bus.mem_rd   = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      stepCycle();
      if (bus.port_req) hi++;
      if (bus.mem_ready) done = 1'b1;
    end
    checks++;
    if (done !== 1'b1 || hi != TIMEOUT) begin
      errors++;
      $display("[TB] FAIL tmo_length got done %b req_cycles %0d want 1 %0d", done, hi, TIMEOUT);
    end
    checks++;
    if ({bus.bus_err, bus.port_req, bus.mem_rdata} !== {2'b10, 32'h12345678}) begin
      errors++;
      $display("[TB] FAIL tmo_abort got err %b req %b data %h want 1 0 12345678",
               bus.bus_err, bus.port_req, bus.mem_rdata);
    end
    bus.mem_rd = 1'b0;
    respNever  = 1'b0;
    stepCycle();
    checks++;
    if ({bus.bus_err, bus.mem_ready} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL tmo_pulse_end got err %b rdy %b want 0 0", bus.bus_err, bus.mem_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit sawReady = 1'b0;
    respNever   = 1'b1;
    memArr[18]  = 32'h600DCAFE;
    bus.if_addr = 32'h48;
    bus.if_req  = 1'b1;
    stepCycle();
    checks++;
    if (bus.port_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstmid_grant got %b want 1", bus.port_req);
    end
    repeat (3) stepCycle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.port_req, bus.if_ready} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rstmid_async got req %b rdy %b want 0 0", bus.port_req, bus.if_ready);
    end
    repeat (2) begin
      stepCycle();
      if (bus.if_ready || bus.port_req) sawReady = 1'b1;
    end
    checks++;
    if (sawReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_silent got activity %b want 0", sawReady);
    end
    respNever   = 1'b0;
    respMaxWait = 0;
    rst_n       = 1'b1;
    stepCycle();
    checks++;
    if ({bus.port_req, bus.port_addr} !== {1'b1, 32'h48}) begin
      errors++;
      $display("[TB] FAIL rstmid_regrant got req %b addr %h want 1 00000048", bus.port_req, bus.port_addr);
    end
    stepCycle();
    checks++;
    if ({bus.if_ready, bus.if_rdata} !== {1'b1, 32'h600DCAFE}) begin
      errors++;
      $display("[TB] FAIL rstmid_ready got rdy %b data %h want 1 600dcafe", bus.if_ready, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    stepCycle();
  endtask

  task automatic test_both_late_ack();
    respMaxWait   = 0;
    bus.mem_rd    = 1'b1;
    bus.mem_wr    = 1'b1;
    bus.mem_addr  = 32'h50;
    bus.mem_wdata = 32'hCAFEF00D;
    stepCycle();
    checks++;
    if ({bus.port_req, bus.port_we, bus.port_addr, bus.port_wdata} !== {2'b11, 32'h50, 32'hCAFEF00D}) begin
      errors++;
      $display("[TB] FAIL both_we got req %b we %b addr %h wdata %h want 1 1 00000050 cafef00d",
               bus.port_req, bus.port_we, bus.port_addr, bus.port_wdata);
    end
    stepCycle();
    checks++;
    if ({bus.mem_ready, bus.bus_err, bus.mem_rdata} !== {2'b10, 32'h0}) begin
      errors++;
      $display("[TB] FAIL both_ready got rdy %b err %b data %h want 1 0 00000000",
               bus.mem_ready, bus.bus_err, bus.mem_rdata);
    end
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    stepCycle();
    respEnable     = 1'b0;
    bus.port_ack   = 1'b1;
    bus.port_rdata = 32'hFFFFFFFF;
    for (int c = 0; c < 2; c++) begin
      stepCycle();
      checks++;
      if ({bus.if_ready, bus.mem_ready, bus.bus_err, bus.port_req, bus.mem_rdata} !== {4'b0000, 32'h0}) begin
        errors++;
        $display("[TB] FAIL late_ack%0d got rdy %b%b err %b req %b data %h want 0 0 0 0 00000000",
                 c, bus.if_ready, bus.mem_ready, bus.bus_err, bus.port_req, bus.mem_rdata);
      end
    end
    bus.port_ack = 1'b0;
    respEnable   = 1'b1;
    checks++;
    if (memArr[20] !== 32'hCAFEF00D) begin
      errors++;
      $display("[TB] FAIL both_write got %h want cafef00d", memArr[20]);
    end
  endtask

  task automatic test_random_traffic();
    bit          ifPend = 1'b0, memPend = 1'b0, memW = 1'b0, memR = 1'b0;
    logic [31:0] ifA = '0, memA = '0, memD = '0;
    logic [31:0] expData = '0, grantAddr = '0, memRdM = '0;
    int          outst = 0, expReady = 0, starveM = 0, nextArb = 0, k = 0;
    bit          expIfRdy, expMemRdy, expGrant, memWin, expWe, quiet;

    clearInputs();
    #2 rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    nextArb = cycleNo + 1;
    respMaxWait = 3;
    for (int i = 0; i < 64; i++) refMem[i] = memArr[i];

    for (int it = 0; it < 700; it++) begin
      stepCycle();
      quiet     = (it >= 650);
      expIfRdy  = (outst == 1) && (cycleNo == expReady);
      expMemRdy = (outst == 2) && (cycleNo == expReady);

      checks++;
      if ({bus.if_ready, bus.mem_ready, bus.bus_err} !== {expIfRdy, expMemRdy, 1'b0}) begin
        errors++;
        $display("[TB] FAIL rnd_ready cyc %0d got %b want %b", cycleNo,
                 {bus.if_ready, bus.mem_ready, bus.bus_err}, {expIfRdy, expMemRdy, 1'b0});
      end
      checks++;
      if ({bus.if_stall, bus.mem_stall} !== {ifPend && !expIfRdy, memPend && !expMemRdy}) begin
        errors++;
        $display("[TB] FAIL rnd_stall cyc %0d got %b want %b", cycleNo,
                 {bus.if_stall, bus.mem_stall}, {ifPend && !expIfRdy, memPend && !expMemRdy});
      end

      expGrant = (outst == 0) && (cycleNo >= nextArb) && (ifPend || memPend);
      checks++;
      if (reqRose !== expGrant) begin
        errors++;
        $display("[TB] FAIL rnd_grant cyc %0d got %b want %b", cycleNo, reqRose, expGrant);
      end

      if (expGrant) begin
        memWin = memPend && !(ifPend && starveM == STARVE_MAX);
        if (memWin) begin
          outst     = 2;
          grantAddr = memA;
          expWe     = memW;
          expData   = memW ? memRdM : refMem[memA[7:2]];
          if (!ifPend) starveM = 0;
          else if (starveM < STARVE_MAX) starveM++;
        end else begin
          outst     = 1;
          grantAddr = ifA;
          expWe     = 1'b0;
          expData   = refMem[ifA[7:2]];
          starveM   = 0;
        end
        expReady = cycleNo + respWait + 1;
        checks++;
        if ({bus.port_we, bus.port_addr} !== {expWe, grantAddr}) begin
          errors++;
          $display("[TB] FAIL rnd_winner cyc %0d got we %b addr %h want we %b addr %h",
                   cycleNo, bus.port_we, bus.port_addr, expWe, grantAddr);
        end
        if (memWin && memW) begin
          checks++;
          if (bus.port_wdata !== memD) begin
            errors++;
            $display("[TB] FAIL rnd_wdata cyc %0d got %h want %h", cycleNo, bus.port_wdata, memD);
          end
        end
      end else if (outst != 0 && cycleNo < expReady) begin
        checks++;
        if ({bus.port_req, bus.port_addr} !== {1'b1, grantAddr}) begin
          errors++;
          $display("[TB] FAIL rnd_hold cyc %0d got req %b addr %h want 1 %h",
                   cycleNo, bus.port_req, bus.port_addr, grantAddr);
        end
      end

      if (expIfRdy) begin
        checks++;
        if (bus.if_rdata !== expData) begin
          errors++;
          $display("[TB] FAIL rnd_if_rdata cyc %0d got %h want %h", cycleNo, bus.if_rdata, expData);
        end
        outst   = 0;
        nextArb = cycleNo + 2;
        ifPend  = !quiet && ($urandom_range(1, 0) == 1);
        if (ifPend) ifA = {24'h0, 6'($urandom), 2'b00};
      end else if (expMemRdy) begin
        checks++;
        if (bus.mem_rdata !== expData) begin
          errors++;
          $display("[TB] FAIL rnd_mem_rdata cyc %0d got %h want %h", cycleNo, bus.mem_rdata, expData);
        end
        if (memW) refMem[memA[7:2]] = memD;
        else      memRdM = expData;
        outst   = 0;
        nextArb = cycleNo + 2;
        memPend = !quiet && ($urandom_range(1, 0) == 1);
        if (memPend) begin
          k    = int'($urandom_range(2, 0));
          memR = (k != 1);
          memW = (k != 0);
          memA = {24'h0, 6'($urandom), 2'b00};
          memD = $urandom;
        end
      end

      if (!quiet && !ifPend && !expIfRdy && $urandom_range(2, 0) == 0) begin
        ifPend = 1'b1;
        ifA    = {24'h0, 6'($urandom), 2'b00};
      end
      if (!quiet && !memPend && !expMemRdy && $urandom_range(2, 0) == 0) begin
        memPend = 1'b1;
        k    = int'($urandom_range(2, 0));
        memR = (k != 1);
        memW = (k != 0);
        memA = {24'h0, 6'($urandom), 2'b00};
        memD = $urandom;
      end

      bus.if_req    = ifPend;
      bus.if_addr   = ifA;
      bus.mem_rd    = memPend && memR;
      bus.mem_wr    = memPend && memW;
      bus.mem_addr  = memA;
      bus.mem_wdata = memD;
    end

    checks++;
    if ({outst != 0, ifPend, memPend} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rnd_drain got outst %0d if %b mem %b want 0 0 0", outst, ifPend, memPend);
    end
  endtask

  initial begin
    clearInputs();
    bus.port_ack   = 1'b0;
    bus.port_rdata = '0;
    for (int i = 0; i < 64; i++) memArr[i] = $urandom;

    test_reset();
    test_if_read();
    test_priority();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_both_late_ack();
    test_random_traffic();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
